// File: rtl/cam_op_sequencer_if.sv
// cam_op_sequencer_if
//   Bundles every signal between the CAM operation sequencer and its two
//   neighbours: the command/response handshake toward the host front end and
//   the port set of the CAM array itself.
//
//   Command side : cmd_valid/cmd_ready handshake with cmd_op, cmd_addr,
//                  cmd_data, cmd_key and cmd_mask.
//   Response side: rsp_valid/rsp_ready handshake with rsp_data, rsp_hit,
//                  rsp_index and rsp_count.
//   CAM side     : cam_addr, cam_dina, cam_key, cam_mask and cam_wea toward
//                  the array; cam_doutb and cam_tags back from it.
//
//   slave  - used by the sequencer (it serves commands and drives the CAM).
//   master - used by whatever surrounds it (host plus CAM array).
interface cam_op_sequencer_if #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = $clog2(CELL_QUANT)
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [WORD_SIZE-1:0]  cmd_data;
    logic [WORD_SIZE-1:0]  cmd_key;
    logic [WORD_SIZE-1:0]  cmd_mask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_SIZE-1:0]  rsp_data;
    logic                  rsp_hit;
    logic [ADDR_W-1:0]     rsp_index;
    logic [ADDR_W:0]       rsp_count;

    logic [ADDR_W-1:0]     cam_addr;
    logic [WORD_SIZE-1:0]  cam_dina;
    logic [WORD_SIZE-1:0]  cam_key;
    logic [WORD_SIZE-1:0]  cam_mask;
    logic                  cam_wea;
    logic [WORD_SIZE-1:0]  cam_doutb;
    logic [CELL_QUANT-1:0] cam_tags;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask,
        input  rsp_ready, cam_doutb, cam_tags,
        output cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_index, rsp_count,
        output cam_addr, cam_dina, cam_key, cam_mask, cam_wea
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask,
        output rsp_ready, cam_doutb, cam_tags,
        input  cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_index, rsp_count,
        input  cam_addr, cam_dina, cam_key, cam_mask, cam_wea
    );
endinterface

// File: rtl/cam_op_sequencer.sv
// cam_op_sequencer
//   Command-level controller for the CAM array. Accepts one command at a
//   time (WRITE, READ, SEARCH, WRITE_TAGGED), sequences the CAM ports with
//   registered outputs and returns a single response per command.
//
//   Ports:
//     CLK100MHZ - system clock, all logic on the rising edge
//     rst       - synchronous reset, active-low
//     bus       - cam_op_sequencer_if.slave: command handshake, response
//                 handshake and the CAM port set
module cam_op_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = $clog2(CELL_QUANT),
    parameter int TAG_LAT    = 2,
    parameter int READ_LAT   = 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    cam_op_sequencer_if.slave    bus
);

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WT     = 2'd3;
    localparam int         MAX_LAT   = (TAG_LAT > READ_LAT) ? TAG_LAT : READ_LAT;
    localparam int         WAIT_W    = $clog2(MAX_LAT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE, WR, RD_WAIT, SRCH_WAIT, SCAN, WT_WRITE, WT_GAP, RESP
    } state_t;

    state_t                state, state_nxt;

    logic [1:0]            op_r;
    logic [WORD_SIZE-1:0]  data_r;
    logic [CELL_QUANT-1:0] tags_r;
    logic [ADDR_W-1:0]     scan_ptr;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [ADDR_W-1:0]     cam_addr_r;
    logic [WORD_SIZE-1:0]  cam_dina_r;
    logic [WORD_SIZE-1:0]  cam_key_r;
    logic [WORD_SIZE-1:0]  cam_mask_r;
    logic                  cam_wea_r;

    logic [WORD_SIZE-1:0]  rsp_data_r;
    logic                  rsp_hit_r;
    logic [ADDR_W-1:0]     rsp_index_r;
    logic [ADDR_W:0]       rsp_count_r;

    logic                  accept;
    logic                  cur_tag;
    logic                  last_row;

    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign cur_tag  = tags_r[scan_ptr];
    assign last_row = (scan_ptr == ADDR_W'(CELL_QUANT - 1));

    // Key/mask become valid at the CAM one cycle after acceptance; the wait
    // counters start from 0 in that cycle, so tags are sampled on the cycle
    // where they have had TAG_LAT full cycles to settle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_WRITE: state_nxt = WR;
                        OP_READ:  state_nxt = RD_WAIT;
                        default:  state_nxt = SRCH_WAIT;
                    endcase
                end
            end
            WR:        state_nxt = RESP;
            RD_WAIT:   if (wait_cnt == WAIT_W'(READ_LAT)) state_nxt = RESP;
            SRCH_WAIT: if (wait_cnt == WAIT_W'(TAG_LAT))  state_nxt = SCAN;
            SCAN: begin
                if ((op_r == OP_WT) && cur_tag) state_nxt = WT_WRITE;
                else if (last_row)              state_nxt = RESP;
            end
            WT_WRITE:  state_nxt = WT_GAP;
            WT_GAP:    state_nxt = last_row ? RESP : SCAN;
            RESP:      if (bus.rsp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            op_r        <= '0;
            data_r      <= '0;
            tags_r      <= '0;
            scan_ptr    <= '0;
            wait_cnt    <= '0;
            cam_addr_r  <= '0;
            cam_dina_r  <= '0;
            cam_key_r   <= '0;
            cam_mask_r  <= '0;
            cam_wea_r   <= 1'b0;
            rsp_data_r  <= '0;
            rsp_hit_r   <= 1'b0;
            rsp_index_r <= '0;
            rsp_count_r <= '0;
        end else begin
            // Registered from the next state: WR and WT_WRITE each last one
            // cycle and are always followed by a non-write state, so wea
            // never stays high across two consecutive cycles.
            cam_wea_r <= (state_nxt == WR) || (state_nxt == WT_WRITE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r        <= bus.cmd_op;
                        data_r      <= bus.cmd_data;
                        wait_cnt    <= '0;
                        rsp_data_r  <= '0;
                        rsp_hit_r   <= 1'b0;
                        rsp_index_r <= '0;
                        rsp_count_r <= '0;
                        case (bus.cmd_op)
                            OP_WRITE: begin
                                cam_addr_r <= bus.cmd_addr;
                                cam_dina_r <= bus.cmd_data;
                            end
                            OP_READ: cam_addr_r <= bus.cmd_addr;
                            default: begin
                                cam_key_r  <= bus.cmd_key;
                                cam_mask_r <= bus.cmd_mask;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (state_nxt == RESP) rsp_data_r <= bus.cam_doutb;
                end
                SRCH_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    // Snapshot: rows rewritten during WRITE_TAGGED never retag.
                    if (state_nxt == SCAN) begin
                        tags_r   <= bus.cam_tags;
                        scan_ptr <= '0;
                    end
                end
                SCAN: begin
                    if (cur_tag) begin
                        rsp_count_r <= rsp_count_r + (ADDR_W + 1)'(1);
                        if (!rsp_hit_r) begin
                            rsp_hit_r   <= 1'b1;
                            rsp_index_r <= scan_ptr;
                        end
                    end
                    // A tagged row in WRITE_TAGGED keeps the pointer; WT_GAP
                    // advances it after the write.
                    if (state_nxt == WT_WRITE) begin
                        cam_addr_r <= scan_ptr;
                        cam_dina_r <= data_r;
                    end else if (!last_row) begin
                        scan_ptr <= scan_ptr + ADDR_W'(1);
                    end
                end
                WT_GAP: begin
                    if (!last_row) scan_ptr <= scan_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_hit   = rsp_hit_r;
    assign bus.rsp_index = rsp_index_r;
    assign bus.rsp_count = rsp_count_r;
    assign bus.cam_addr  = cam_addr_r;
    assign bus.cam_dina  = cam_dina_r;
    assign bus.cam_key   = cam_key_r;
    assign bus.cam_mask  = cam_mask_r;
    assign bus.cam_wea   = cam_wea_r;

endmodule

// File: tb/tb_cam_op_sequencer.sv
// tb_cam_op_sequencer
//   Directed bench for cam_op_sequencer with an 8-row, 8-bit behavioural CAM.
//   Expected responses come from a reference memory model and are queued at
//   command issue, then popped when the DUT presents its response.
module tb_cam_op_sequencer;

    localparam int WS = 8;
    localparam int CQ = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic [WS-1:0] data;
        logic          hit;
        logic [AW-1:0] index;
        logic [AW:0]   count;
    } rsp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   acc_cyc;

    cam_op_sequencer_if #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW)) bus();

    cam_op_sequencer #(
        .WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW), .TAG_LAT(2), .READ_LAT(1)
    ) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CAM: registered read (1 cycle), two-stage tag pipeline.
    logic [WS-1:0] cam_mem [CQ];
    logic [WS-1:0] doutb_r;
    logic [CQ-1:0] tag_s1, tag_s2;
    bit            cam_init_done;

    always @(posedge clk) begin
        if (!cam_init_done) begin
            for (int i = 0; i < CQ; i++) cam_mem[i] <= '0;
            cam_init_done <= 1'b1;
        end else if (bus.cam_wea) begin
            cam_mem[bus.cam_addr] <= bus.cam_dina;
        end
        doutb_r <= cam_mem[bus.cam_addr];
        for (int i = 0; i < CQ; i++)
            tag_s1[i] <= (((cam_mem[i] ^ bus.cam_key) & bus.cam_mask) == '0);
        tag_s2 <= tag_s1;
    end

    assign bus.cam_doutb = doutb_r;
    assign bus.cam_tags  = tag_s2;

    // Write-pulse monitor.
    int            wea_pulses;
    int            gap_viol;
    logic          prev_wea;
    logic [AW-1:0] wr_log [$];

    always @(negedge clk) begin
        if (bus.cam_wea === 1'b1) begin
            wr_log.push_back(bus.cam_addr);
            wea_pulses++;
            if (prev_wea === 1'b1) gap_viol++;
        end
        prev_wea = bus.cam_wea;
    end

    // Reference model and scoreboard.
    logic [WS-1:0] ref_mem [CQ];
    rsp_t          exp_q [$];

    function automatic rsp_t model(input logic [1:0] op, input logic [AW-1:0] addr,
                                   input logic [WS-1:0] data, key, mask);
        rsp_t          r;
        logic [CQ-1:0] hits;
        r    = '0;
        hits = '0;
        case (op)
            2'd0: ref_mem[addr] = data;
            2'd1: r.data = ref_mem[addr];
            default: begin
                for (int i = 0; i < CQ; i++) begin
                    if (((ref_mem[i] ^ key) & mask) == '0) begin
                        if (!r.hit) r.index = AW'(i);
                        r.hit   = 1'b1;
                        r.count = r.count + 4'd1;
                        hits[i] = 1'b1;
                    end
                end
                if (op == 2'd3)
                    for (int i = 0; i < CQ; i++) if (hits[i]) ref_mem[i] = data;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [WS-1:0] data, key, mask);
        exp_q.push_back(model(op, addr, data, key, mask));
        bus.cmd_op   = op;
        bus.cmd_addr = addr;
        bus.cmd_data = data;
        bus.cmd_key  = key;
        bus.cmd_mask = mask;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [WS-1:0] data, key, mask);
        int n;
        drive(op, addr, data, key, mask);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int exp_lat);
        int   n;
        rsp_t e;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) break;
            n++;
            if (n > 200) break;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '0;
        if (bus.rsp_valid !== 1'b1) begin
            chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_data"},  32'(bus.rsp_data),  32'(e.data));
        chk({tag, "_hit"},   32'(bus.rsp_hit),   32'(e.hit));
        chk({tag, "_index"}, 32'(bus.rsp_index), 32'(e.index));
        chk({tag, "_count"}, 32'(bus.rsp_count), 32'(e.count));
        if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int   p;
        int   mark;
        int   n;
        rsp_t e;

        checks = 0;
        errors = 0;
        for (int i = 0; i < CQ; i++) ref_mem[i] = '0;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_key   = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cam_wea",   32'(bus.cam_wea),   32'd0);
        chk("rst_cam_addr",  32'(bus.cam_addr),  32'd0);
        chk("rst_cam_key",   32'(bus.cam_key),   32'd0);
        chk("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        rst = 1'b1;

        // WRITE then READ of the same row.
        p    = wea_pulses;
        mark = wr_log.size();
        send(2'd0, 3'd5, 8'hA5, 8'h00, 8'h00);
        recv("write5", 2);
        chk("write5_pulses", 32'(wea_pulses - p), 32'd1);
        chk("write5_addr", 32'(wr_log.size() > mark ? wr_log[mark] : 3'd0), 32'd5);
        send(2'd1, 3'd5, 8'h00, 8'h00, 8'h00);
        recv("read5", 0);

        // Rows 1,3,6 = 0x3C, everything else 0x00.
        send(2'd0, 3'd5, 8'h00, 8'h00, 8'h00); recv("clr5", 2);
        send(2'd0, 3'd1, 8'h3C, 8'h00, 8'h00); recv("wr1", 2);
        send(2'd0, 3'd3, 8'h3C, 8'h00, 8'h00); recv("wr3", 2);
        send(2'd0, 3'd6, 8'h3C, 8'h00, 8'h00); recv("wr6", 2);

        send(2'd2, 3'd0, 8'h00, 8'h3C, 8'hFF);
        recv("search3c", 12);

        // WRITE_TAGGED over the same contents.
        mark = wr_log.size();
        send(2'd3, 3'd0, 8'h77, 8'h3C, 8'hFF);
        recv("wtag", 0);
        chk("wtag_nwrites", 32'(wr_log.size() - mark), 32'd3);
        chk("wtag_row_a", 32'(wr_log.size() > mark     ? wr_log[mark]     : 3'd0), 32'd1);
        chk("wtag_row_b", 32'(wr_log.size() > mark + 1 ? wr_log[mark + 1] : 3'd0), 32'd3);
        chk("wtag_row_c", 32'(wr_log.size() > mark + 2 ? wr_log[mark + 2] : 3'd0), 32'd6);
        chk("wea_gap_violations", 32'(gap_viol), 32'd0);
        for (int r = 0; r < CQ; r++) begin
            send(2'd1, AW'(r), 8'h00, 8'h00, 8'h00);
            recv($sformatf("readback%0d", r), 0);
        end

        // No match, then all match.
        p = wea_pulses;
        send(2'd2, 3'd0, 8'h00, 8'hFF, 8'hFF);
        recv("search_none", 12);
        send(2'd3, 3'd0, 8'h99, 8'hFF, 8'hFF);
        recv("wtag_none", 0);
        chk("wtag_none_pulses", 32'(wea_pulses - p), 32'd0);
        send(2'd2, 3'd0, 8'h00, 8'h12, 8'h00);
        recv("search_all", 12);

        // Response back-pressure with a queued command.
        send(2'd2, 3'd0, 8'h00, 8'h77, 8'hFF);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        drive(2'd1, 3'd3, 8'h00, 8'h00, 8'h00);
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid",     32'(bus.rsp_valid), 32'd1);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("stall_hit",       32'(bus.rsp_hit),   32'(e.hit));
            chk("stall_index",     32'(bus.rsp_index), 32'(e.index));
            chk("stall_count",     32'(bus.rsp_count), 32'(e.count));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        chk("post_rsp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rsp_valid",     32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("queued_accepted", 32'(bus.cmd_ready), 32'd0);
        recv("queued_read", 0);

        // Reset in the middle of a WRITE_TAGGED that tags every row.
        send(2'd3, 3'd0, 8'h5A, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_wea",       32'(bus.cam_wea),   32'd0);
            chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b1;
        exp_q.delete();
        p = wea_pulses;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", 32'(wea_pulses - p), 32'd0);
        chk("midrst_no_rsp",    32'(bus.rsp_valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_op_sequencer.md
Name: cam_op_sequencer

Overview:
Command-level controller for the CAM array. It accepts one command at a time over a valid/ready interface and drives the CAM's addr_in/dina/key/mask/wea ports. It also reads the CAM's doutb and tag vector. Commands: single-row write, single-row read, associative search (first-match index + match count), and masked write-to-all-tagged-rows. It sits between the host/instruction front end and the CAM instance.

Parameters:
WORD_SIZE, 8, CAM word width
CELL_QUANT, 512, number of CAM rows
ADDR_W, clog2(CELL_QUANT) (9), row index width
TAG_LAT, 2, cycles from key/mask stable to tags valid
READ_LAT, 1, cycles from cam_addr stable to cam_doutb valid

Ports:
CLK100MHZ  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, command accepted when valid&ready
cmd_op  in  2  0=WRITE 1=READ 2=SEARCH 3=WRITE_TAGGED
cmd_addr  in  ADDR_W  row for WRITE/READ
cmd_data  in  WORD_SIZE  write data for WRITE/WRITE_TAGGED
cmd_key  in  WORD_SIZE  search key
cmd_mask  in  WORD_SIZE  search mask
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  WORD_SIZE  READ data, else 0
rsp_hit  out  1  at least one tagged row (SEARCH/WRITE_TAGGED)
rsp_index  out  ADDR_W  lowest tagged row index, 0 if none
rsp_count  out  ADDR_W+1  number of tagged rows
cam_addr  out  ADDR_W  to CAM addr_in
cam_dina  out  WORD_SIZE  to CAM dina
cam_key  out  WORD_SIZE  to CAM key
cam_mask  out  WORD_SIZE  to CAM mask
cam_wea  out  1  to CAM wea
cam_doutb  in  WORD_SIZE  from CAM doutb
cam_tags  in  CELL_QUANT  from CAM match tags

Behaviour:
- Reset (rst=0 at edge): state IDLE. cmd_ready=1, rsp_valid=0, cam_wea=0. cam_addr/dina/key/mask=0, rsp_* = 0. Reset mid-command aborts it at that edge; any in-flight response is dropped.
- All CAM-side outputs are registered. The command fields are latched on acceptance. cmd_ready=1 only in IDLE.
- CAM write-decode rule: cam_wea high for exactly one cycle per row write. It is followed by at least one cycle low before the next write, because the CAM's enable decode does not self-clear while wea stays high.
- States: IDLE, WR, RD_WAIT, SRCH_WAIT, SCAN, WT_WRITE, WT_GAP, RESP.
- WRITE: IDLE->WR. Drive cam_addr=cmd_addr, cam_dina=cmd_data, cam_wea=1 for 1 cycle, then RESP. Response has rsp_data=0 and hit/index/count=0. Accept-to-rsp_valid is 2 cycles.
- READ: drive cam_addr, wait READ_LAT cycles in RD_WAIT, capture cam_doutb into rsp_data, then RESP.
- SEARCH: drive cam_key/cam_mask, wait TAG_LAT cycles in SRCH_WAIT, then snapshot cam_tags into an internal register. SCAN walks rows 0..CELL_QUANT-1, one per cycle. For each set bit it increments the count; the first set bit records the index. After the last row it goes to RESP. Total accept-to-rsp_valid = 1+TAG_LAT+CELL_QUANT+1 cycles.
- WRITE_TAGGED: same snapshot as SEARCH. The scan pointer advances one row per cycle over untagged rows. On a tagged row: WT_WRITE (cam_addr=row, cam_dina=cmd_data, cam_wea=1), then WT_GAP (cam_wea=0), then the next row. Writes use the snapshot, so rows changed mid-operation do not retag. The response carries hit/index/count of the snapshot.
- Zero matches: rsp_hit=0, rsp_index=0, rsp_count=0, and no writes are issued. All rows matching: rsp_count=CELL_QUANT, which needs the ADDR_W+1 width.
- cam_key/cam_mask hold their last values after a command. cam_wea=0 outside WR/WT_WRITE.
- RESP: rsp_valid=1 and rsp_* are stable until rsp_ready. On the handshake edge the block returns to IDLE (cmd_ready=1 next cycle). rsp_ready while rsp_valid=0 is ignored. A command offered during RESP waits.

Test Plan:
(All cases use CELL_QUANT=8, WORD_SIZE=8, TAG_LAT=2, READ_LAT=1, with a behavioural CAM model.)
- Reset: hold rst=0 for 3 cycles mid-WRITE_TAGGED -> cam_wea=0 and rsp_valid=0 from the next edge, cmd_ready=1 after release.
- WRITE addr=5 data=0xA5, then READ addr=5 -> rsp_data=0xA5. Exactly one cam_wea pulse. WRITE response 2 cycles after accept.
- Rows 1,3,6=0x3C, others 0x00. SEARCH key=0x3C mask=0xFF -> rsp_hit=1, rsp_index=1, rsp_count=3, rsp_valid 12 cycles after accept.
- Same contents, WRITE_TAGGED key=0x3C mask=0xFF data=0x77 -> writes to rows 1,3,6 only, each cam_wea pulse followed by a low cycle. Readback shows 0x77 on those rows and 0x00 elsewhere. rsp_count=3.
- SEARCH key=0xFF mask=0xFF with no match -> rsp_hit=0, rsp_index=0, rsp_count=0. Mask=0x00 -> rsp_count=8, rsp_index=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 with cmd_valid=1. Raise rsp_ready -> cmd_ready=1 next cycle and the queued command is accepted.
